// File: rtl/check_sched.sv
// Shared-checker scheduler: round-robin grant of NREQ check sources onto one registered compare unit.
// Define CHECK_SCHED_ASSERT_EN to compile in handshake/result assertions.
// Handshake: a check transfers on a cycle where req_valid[i] && req_ready[i]; req_ready is one-hot-or-zero.
module check_sched #(
   parameter  int NREQ = 4,
   parameter  int DW   = 32,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*DW-1:0]   req_a,
   input  logic [NREQ*DW-1:0]   req_b,
   input  logic [NREQ*2-1:0]    req_mode,
   input  logic [NREQ-1:0]      mask,
   input  logic [NREQ-1:0]      fatal_mask,
   input  logic                 flush,
   input  logic                 clear_fatal,
   output logic                 res_valid,
   output logic [IDW-1:0]       res_id,
   output logic                 res_pass,
   output logic [15:0]          fail_count,
   output logic                 fatal
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   logic [1:0]      r_state;
   logic [IDW-1:0]  r_rr_ptr;
   logic [IDW-1:0]  r_id;
   logic [IDW-1:0]  r_res_id;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic [1:0]      r_mode;
   logic            r_pass;
   logic [15:0]     r_fail_count;
   logic            r_fatal;

   logic            w_found;
   logic [IDW-1:0]  w_gnt_id;
   logic [IDW-1:0]  w_next_ptr;
   logic [NREQ-1:0] w_ready;
   logic            w_accept;
   logic            w_pass;
   logic            w_report;
   logic            w_fail;
   logic            w_set_fatal;
   int              w_idx;

   // First valid requester at or after r_rr_ptr, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(r_rr_ptr) + k) % NREQ;
         if (!w_found && req_valid[w_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (!rst && (r_state == S_IDLE) && !flush && w_found)
         w_ready[w_gnt_id] = 1'b1;
   end

   assign w_accept   = |(req_valid & w_ready);
   assign w_next_ptr = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + 1'b1;

   always_comb begin
      case (r_mode)
         2'b01:   w_pass = (r_a != '0) && (r_b != '0);
         2'b10:   w_pass = (r_a != '0) || (r_b != '0);
         default: w_pass = (r_a == r_b);
      endcase
   end

   // A masked requester is drained through REPORT silently.
   assign w_report    = (r_state == S_REPORT) && !flush && !mask[r_res_id];
   assign w_fail      = w_report && !r_pass;
   assign w_set_fatal = w_fail && fatal_mask[r_res_id];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rr_ptr     <= '0;
         r_id         <= '0;
         r_res_id     <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_mode       <= '0;
         r_pass       <= 1'b0;
         r_fail_count <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_id     <= w_gnt_id;
                  r_a      <= req_a[int'(w_gnt_id)*DW +: DW];
                  r_b      <= req_b[int'(w_gnt_id)*2*DW/2 +: DW];
                  r_mode   <= req_mode[int'(w_gnt_id)*2 +: 2];
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_pass   <= w_pass;
                  r_res_id <= r_id;
                  r_state  <= S_REPORT;
               end
            end
            S_REPORT: begin
               r_state <= S_IDLE;
               if (w_fail && (r_fail_count != 16'hFFFF))
                  r_fail_count <= r_fail_count + 16'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Set wins over a coincident clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_fatal <= 1'b0;
      else if (w_set_fatal)
         r_fatal <= 1'b1;
      else if (clear_fatal)
         r_fatal <= 1'b0;
   end

   assign req_ready  = w_ready;
   assign res_valid  = w_report;
   assign res_id     = r_res_id;
   assign res_pass   = r_pass;
   assign fail_count = r_fail_count;
   assign fatal      = r_fatal;

`ifdef CHECK_SCHED_ASSERT_EN
   always_comb begin
      a_ready_onehot: assert #0 ($onehot0(w_ready))
         else $error("req_ready not one-hot-or-zero");
      a_ready_idle: assert #0 ((r_state == S_IDLE) || (w_ready == '0))
         else $error("req_ready high outside IDLE");
      a_grant_valid: assert #0 ((w_ready & ~req_valid) == '0)
         else $error("grant to requester without req_valid");
      a_res_id: assert #0 (!w_report || (int'(r_res_id) < NREQ))
         else $error("res_id out of range");
   end
`endif

endmodule
